// File: rtl/exception_ctrl_if.sv
// Commit-stage bundle between the pipeline and the exception controller:
// two issue slots, the CP0 view, the CP0 event strobes and the fetch redirect handshake.
interface exception_ctrl_if;
    logic        slot0_valid;
    logic        slot1_valid;
    logic [31:0] slot0_pc;
    logic [31:0] slot1_pc;
    logic        slot0_ds;
    logic        slot1_ds;
    logic [6:0]  slot0_exc;
    logic [6:0]  slot1_exc;
    logic [31:0] slot0_dvaddr;
    logic [31:0] slot1_dvaddr;
    logic        slot0_eret;
    logic        slot1_eret;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;

    logic        has_exp;
    logic        exp_first;
    logic        exp_second;
    logic        exp_clean;
    logic [31:0] exp_epc;
    logic [31:0] exp_badaddress;
    logic [4:0]  exp_cause_code;
    logic        exp_is_in_delayslot;
    logic        wen_badaddress;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output slot0_valid, slot1_valid, slot0_pc, slot1_pc, slot0_ds, slot1_ds,
               slot0_exc, slot1_exc, slot0_dvaddr, slot1_dvaddr, slot0_eret, slot1_eret,
               cp0_status, cp0_cause, cp0_epc, redirect_ready,
        input  has_exp, exp_first, exp_second, exp_clean, exp_epc, exp_badaddress,
               exp_cause_code, exp_is_in_delayslot, wen_badaddress, flush,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  slot0_valid, slot1_valid, slot0_pc, slot1_pc, slot0_ds, slot1_ds,
               slot0_exc, slot1_exc, slot0_dvaddr, slot1_dvaddr, slot0_eret, slot1_eret,
               cp0_status, cp0_cause, cp0_epc, redirect_ready,
        output has_exp, exp_first, exp_second, exp_clean, exp_epc, exp_badaddress,
               exp_cause_code, exp_is_in_delayslot, wen_badaddress, flush,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exception_ctrl.sv
// Dual-issue commit exception controller: picks the winning slot event, strobes CP0
// for one cycle and holds flush/redirect until fetch accepts the new PC.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic              clk,
    input  logic              reset,
    exception_ctrl_if.slave   bus
);

    typedef enum logic {IDLE, REDIRECT} state_e;

    typedef struct packed {
        logic       hit;
        logic       eret;
        logic [4:0] code;
        logic       wbad;
        logic       bad_pc;
    } slot_evt_t;

    // Priority: interrupt, AdEL fetch, RI, Ov, Sys, Bp, AdEL data, AdES; ERET only when nothing else.
    function automatic slot_evt_t decode_slot(input logic valid, input logic intr,
                                              input logic [6:0] exc, input logic eret);
        slot_evt_t ev;
        ev     = '0;
        ev.hit = valid & (intr | (|exc) | eret);
        if (intr)        ev.code = 5'd0;
        else if (exc[0]) begin ev.code = 5'd4; ev.wbad = 1'b1; ev.bad_pc = 1'b1; end
        else if (exc[1]) ev.code = 5'd10;
        else if (exc[2]) ev.code = 5'd12;
        else if (exc[3]) ev.code = 5'd8;
        else if (exc[4]) ev.code = 5'd9;
        else if (exc[5]) begin ev.code = 5'd4; ev.wbad = 1'b1; end
        else if (exc[6]) begin ev.code = 5'd5; ev.wbad = 1'b1; end
        else if (eret)   ev.eret = 1'b1;
        if (!valid) ev = '0;
        return ev;
    endfunction

    state_e      state_q, state_d;
    logic        has_exp_q, has_exp_d;
    logic        first_q, first_d;
    logic        second_q, second_d;
    logic        clean_q, clean_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bad_q, bad_d;
    logic [4:0]  code_q, code_d;
    logic        dsl_q, dsl_d;
    logic        wbad_q, wbad_d;
    logic [31:0] rpc_q, rpc_d;

    logic        int_pend;
    slot_evt_t   ev0, ev1, sel;
    logic [31:0] sel_pc, sel_dv;
    logic        sel_ds;
    logic        unused_bits;

    assign unused_bits = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                           bus.cp0_cause[31:16], bus.cp0_cause[7:0]};

    always_comb begin
        int_pend = bus.cp0_status[0] & ~bus.cp0_status[1]
                 & (|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]));
        // The interrupt belongs to slot1 only when slot0 carries no instruction.
        ev0 = decode_slot(bus.slot0_valid, int_pend, bus.slot0_exc, bus.slot0_eret);
        ev1 = decode_slot(bus.slot1_valid, int_pend & ~bus.slot0_valid,
                          bus.slot1_exc, bus.slot1_eret);
        sel    = ev0.hit ? ev0 : ev1;
        sel_pc = ev0.hit ? bus.slot0_pc : bus.slot1_pc;
        sel_ds = ev0.hit ? bus.slot0_ds : bus.slot1_ds;
        sel_dv = ev0.hit ? bus.slot0_dvaddr : bus.slot1_dvaddr;

        state_d   = state_q;
        has_exp_d = 1'b0;
        first_d   = 1'b0;
        second_d  = 1'b0;
        clean_d   = 1'b0;
        epc_d     = '0;
        bad_d     = '0;
        code_d    = '0;
        dsl_d     = 1'b0;
        wbad_d    = 1'b0;
        rpc_d     = rpc_q;

        case (state_q)
            IDLE: begin
                if (sel.hit) begin
                    state_d   = REDIRECT;
                    has_exp_d = 1'b1;
                    first_d   = ev0.hit;
                    second_d  = ~ev0.hit;
                    code_d    = sel.code;
                    if (sel.eret) begin
                        clean_d = 1'b1;
                        rpc_d   = bus.cp0_epc;
                    end else begin
                        epc_d  = sel_ds ? (sel_pc - 32'd4) : sel_pc;
                        dsl_d  = sel_ds;
                        wbad_d = sel.wbad;
                        if (sel.wbad) bad_d = sel.bad_pc ? sel_pc : sel_dv;
                        rpc_d  = EXC_VECTOR;
                    end
                end
            end
            REDIRECT: begin
                if (bus.redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            has_exp_q <= 1'b0;
            first_q   <= 1'b0;
            second_q  <= 1'b0;
            clean_q   <= 1'b0;
            epc_q     <= '0;
            bad_q     <= '0;
            code_q    <= '0;
            dsl_q     <= 1'b0;
            wbad_q    <= 1'b0;
            rpc_q     <= '0;
        end else begin
            state_q   <= state_d;
            has_exp_q <= has_exp_d;
            first_q   <= first_d;
            second_q  <= second_d;
            clean_q   <= clean_d;
            epc_q     <= epc_d;
            bad_q     <= bad_d;
            code_q    <= code_d;
            dsl_q     <= dsl_d;
            wbad_q    <= wbad_d;
            rpc_q     <= rpc_d;
        end
    end

    assign bus.has_exp             = has_exp_q;
    assign bus.exp_first           = first_q;
    assign bus.exp_second          = second_q;
    assign bus.exp_clean           = clean_q;
    assign bus.exp_epc             = epc_q;
    assign bus.exp_badaddress      = bad_q;
    assign bus.exp_cause_code      = code_q;
    assign bus.exp_is_in_delayslot = dsl_q;
    assign bus.wen_badaddress      = wbad_q;
    assign bus.flush               = (state_q == REDIRECT);
    assign bus.redirect_valid      = (state_q == REDIRECT);
    assign bus.redirect_pc         = rpc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: stimulus pushes hand-computed CP0 events into a
// queue, a negedge monitor pops and compares on every has_exp strobe.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exception_ctrl_if bus();
    exception_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct packed {
        logic        first;
        logic        second;
        logic        clean;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        dsl;
        logic        wbad;
        logic [31:0] bad;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic f, input logic s, input logic c, input logic [4:0] code,
                        input logic [31:0] epc, input logic dsl, input logic wbad,
                        input logic [31:0] badaddr, input logic [31:0] rpc);
        exp_t e;
        e = '{first: f, second: s, clean: c, code: code, epc: epc, dsl: dsl,
              wbad: wbad, bad: badaddr, rpc: rpc};
        exp_q.push_back(e);
    endtask

    // Monitor: every has_exp strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.has_exp === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_has_exp actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                chk("exp_first",      {31'b0, bus.exp_first},           {31'b0, e.first});
                chk("exp_second",     {31'b0, bus.exp_second},          {31'b0, e.second});
                chk("exp_clean",      {31'b0, bus.exp_clean},           {31'b0, e.clean});
                chk("exp_cause_code", {27'b0, bus.exp_cause_code},      {27'b0, e.code});
                chk("exp_epc",        bus.exp_epc,                      e.epc);
                chk("exp_in_ds",      {31'b0, bus.exp_is_in_delayslot}, {31'b0, e.dsl});
                chk("wen_badaddress", {31'b0, bus.wen_badaddress},      {31'b0, e.wbad});
                chk("exp_badaddress", bus.exp_badaddress,               e.bad);
                chk("redirect_pc",    bus.redirect_pc,                  e.rpc);
                chk("flush_at_event", {31'b0, bus.flush},               32'd1);
                chk("rvalid_at_event",{31'b0, bus.redirect_valid},      32'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_in();
        bus.slot0_valid = 0; bus.slot1_valid = 0;
        bus.slot0_pc = '0;   bus.slot1_pc = '0;
        bus.slot0_ds = 0;    bus.slot1_ds = 0;
        bus.slot0_exc = '0;  bus.slot1_exc = '0;
        bus.slot0_dvaddr = '0; bus.slot1_dvaddr = '0;
        bus.slot0_eret = 0;  bus.slot1_eret = 0;
        bus.cp0_status = '0; bus.cp0_cause = '0; bus.cp0_epc = '0;
    endtask

    task automatic s0(input logic v, input logic [31:0] pc, input logic ds, input logic [6:0] exc,
                      input logic [31:0] dv, input logic eret);
        bus.slot0_valid = v; bus.slot0_pc = pc; bus.slot0_ds = ds;
        bus.slot0_exc = exc; bus.slot0_dvaddr = dv; bus.slot0_eret = eret;
    endtask

    task automatic s1(input logic v, input logic [31:0] pc, input logic ds, input logic [6:0] exc,
                      input logic [31:0] dv, input logic eret);
        bus.slot1_valid = v; bus.slot1_pc = pc; bus.slot1_ds = ds;
        bus.slot1_exc = exc; bus.slot1_dvaddr = dv; bus.slot1_eret = eret;
    endtask

    // Inputs were set just after a rising edge; let one edge sample them, then settle.
    task automatic fire();
        tick(1);
        clear_in();
        tick(3);
    endtask

    function automatic logic any_out();
        return |{bus.has_exp, bus.exp_first, bus.exp_second, bus.exp_clean, bus.exp_epc,
                 bus.exp_badaddress, bus.exp_cause_code, bus.exp_is_in_delayslot,
                 bus.wen_badaddress, bus.flush, bus.redirect_valid, bus.redirect_pc};
    endfunction

    initial begin
        int n_flush, n_rv, n_has;
        reset = 1'b1;
        clear_in();
        bus.redirect_ready = 1'b1;
        tick(3);
        @(negedge clk);
        chk("reset_all_zero", {31'b0, any_out()}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1);

        // Overflow in slot0
        s0(1, 32'h8000_0010, 0, 7'b0000100, '0, 0);
        push(1, 0, 0, 5'd12, 32'h8000_0010, 0, 0, '0, VEC);
        fire();

        // AdES in slot1 delay slot, slot0 clean
        s0(1, 32'h8000_0100, 0, 7'b0, '0, 0);
        s1(1, 32'h8000_0104, 1, 7'b1000000, 32'h0000_0003, 0);
        push(0, 1, 0, 5'd5, 32'h8000_0100, 1, 1, 32'h0000_0003, VEC);
        fire();

        // Interrupt beats Sys in slot0 and RI in slot1
        bus.cp0_status = 32'h0000_0401; bus.cp0_cause = 32'h0000_0400;
        s0(1, 32'h8000_0200, 0, 7'b0001000, '0, 0);
        s1(1, 32'h8000_0204, 0, 7'b0000010, '0, 0);
        push(1, 0, 0, 5'd0, 32'h8000_0200, 0, 0, '0, VEC);
        fire();

        // ERET in slot0
        bus.cp0_epc = 32'h8000_2000;
        s0(1, 32'h8000_0300, 0, 7'b0, '0, 1);
        push(1, 0, 1, 5'd0, 32'h0, 0, 0, '0, 32'h8000_2000);
        fire();

        // AdEL fetch wins over RI and AdES; badaddress is the PC
        s0(1, 32'h8000_0400, 0, 7'b1000011, 32'h1234_5678, 0);
        push(1, 0, 0, 5'd4, 32'h8000_0400, 0, 1, 32'h8000_0400, VEC);
        fire();

        // Breakpoint at pc 0 in a delay slot: EPC wraps
        s0(1, 32'h0000_0000, 1, 7'b0010000, '0, 0);
        push(1, 0, 0, 5'd9, 32'hFFFF_FFFC, 1, 0, '0, VEC);
        fire();

        // RI in the same slot beats ERET
        bus.cp0_epc = 32'h8000_2000;
        s0(1, 32'h8000_0500, 0, 7'b0000010, '0, 1);
        push(1, 0, 0, 5'd10, 32'h8000_0500, 0, 0, '0, VEC);
        fire();

        // ERET in slot1 behind a clean slot0
        bus.cp0_epc = 32'h8000_3000;
        s0(1, 32'h8000_0600, 0, 7'b0, '0, 0);
        s1(1, 32'h8000_0604, 0, 7'b0, '0, 1);
        push(0, 1, 1, 5'd0, 32'h0, 0, 0, '0, 32'h8000_3000);
        fire();

        // Interrupt lands on slot1 when slot0 is invalid (slot0 flags ignored)
        bus.cp0_status = 32'h0000_0401; bus.cp0_cause = 32'h0000_0400;
        s0(0, 32'h8000_0700, 0, 7'b0000100, '0, 0);
        s1(1, 32'h8000_0704, 0, 7'b0, '0, 0);
        push(0, 1, 0, 5'd0, 32'h8000_0704, 0, 0, '0, VEC);
        fire();

        // EXL set masks the interrupt: no event
        bus.cp0_status = 32'h0000_0403; bus.cp0_cause = 32'h0000_0400;
        s0(1, 32'h8000_0800, 0, 7'b0, '0, 0);
        tick(1);
        @(negedge clk);
        chk("exl_masks_has_exp", {31'b0, bus.has_exp}, 32'd0);
        chk("exl_masks_flush",   {31'b0, bus.flush},   32'd0);
        @(posedge clk); #1;
        clear_in();
        tick(1);

        // AdEL data in slot1: badaddress from dvaddr
        s0(1, 32'h8000_0900, 0, 7'b0, '0, 0);
        s1(1, 32'h8000_0904, 0, 7'b0100000, 32'hDEAD_BEE0, 0);
        push(0, 1, 0, 5'd4, 32'h8000_0904, 0, 1, 32'hDEAD_BEE0, VEC);
        fire();

        // Syscall in a delay slot
        s0(1, 32'h8000_0A00, 1, 7'b0001000, '0, 0);
        push(1, 0, 0, 5'd8, 32'h8000_09FC, 1, 0, '0, VEC);
        fire();

        // Redirect held off for 3 cycles while new exceptions keep arriving
        bus.redirect_ready = 1'b0;
        s0(1, 32'h8000_0B00, 0, 7'b0000100, '0, 0);
        push(1, 0, 0, 5'd12, 32'h8000_0B00, 0, 0, '0, VEC);
        tick(1);
        s0(1, 32'h8000_0B40, 0, 7'b0001000, '0, 0);
        n_flush = 0; n_rv = 0; n_has = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.flush === 1'b1) n_flush++;
            if (bus.redirect_valid === 1'b1) begin
                n_rv++;
                chk("held_redirect_pc", bus.redirect_pc, VEC);
            end
            if (bus.has_exp === 1'b1) n_has++;
            @(posedge clk); #1;
            if (c == 2) begin
                bus.redirect_ready = 1'b1;
                clear_in();
            end
        end
        chk("held_flush_cycles",  n_flush, 32'd4);
        chk("held_rvalid_cycles", n_rv,    32'd4);
        chk("held_has_exp_count", n_has,   32'd1);

        // Event in the first IDLE cycle after redirect exit is serviced
        s0(1, 32'h8000_0C00, 0, 7'b0000100, '0, 0);
        push(1, 0, 0, 5'd12, 32'h8000_0C00, 0, 0, '0, VEC);
        tick(1);
        tick(1);
        s0(0, '0, 0, 7'b0, '0, 0);
        s1(1, 32'h8000_0C44, 0, 7'b0001000, '0, 0);
        push(0, 1, 0, 5'd8, 32'h8000_0C44, 0, 0, '0, VEC);
        fire();

        // Reset during REDIRECT abandons the handshake; inputs under reset create no event
        bus.redirect_ready = 1'b0;
        s0(1, 32'h8000_0D00, 0, 7'b0000010, '0, 0);
        push(1, 0, 0, 5'd10, 32'h8000_0D00, 0, 0, '0, VEC);
        tick(1);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        chk("reset_in_redirect_zero", {31'b0, any_out()}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_in();
        bus.redirect_ready = 1'b1;
        tick(1);
        @(negedge clk);
        chk("after_reset_flush",   {31'b0, bus.flush},   32'd0);
        chk("after_reset_has_exp", {31'b0, bus.has_exp}, 32'd0);

        tick(5);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
